// File: rtl/multadd_pkg.sv
// Shared types for the multadd FMA unit and its dot-product sequencer.
// Holds the ALU op encoding, the multadd result latency and the sequencer state encoding.
package multadd_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2
    } alu_op_e;

    localparam int MULTADD_LAT_C = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    function automatic int sat_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/multadd_dot_addr_gen.sv
// Element counter plus wrapping address generator for both dot-product operands.
// Latency: addresses valid the cycle after load; no backpressure, advances whenever i_adv is high.
module multadd_dot_addr_gen #(
    parameter int  els_p = 16,
    localparam int aw    = $clog2(els_p),
    localparam int lw    = $clog2(els_p + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_load,
    input  logic [lw-1:0] i_len,
    input  logic [aw-1:0] i_a_base,
    input  logic [aw-1:0] i_b_base,
    input  logic          i_adv,
    output logic [aw-1:0] o_addr_a,
    output logic [aw-1:0] o_addr_b,
    output logic          o_first,
    output logic          o_last
);

    logic [aw-1:0] r_k;
    logic [lw-1:0] r_len;
    logic [aw-1:0] r_a_base;
    logic [aw-1:0] r_b_base;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_k      <= '0;
            r_len    <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
        end else if (i_load) begin
            r_k      <= '0;
            r_len    <= i_len;
            r_a_base <= i_a_base;
            r_b_base <= i_b_base;
        end else if (i_adv) begin
            r_k <= r_k + aw'(1);
        end
    end

    // aw-bit adds wrap modulo els_p since els_p is a power of two
    assign o_addr_a = r_a_base + r_k;
    assign o_addr_b = r_b_base + r_k;
    assign o_first  = (r_k == '0);
    assign o_last   = ((lw'(r_k) + lw'(1)) == r_len);

endmodule

// File: rtl/multadd_dot_seq.sv
// Dot-product issue sequencer driving multadd; result valid len+3 cycles after accept (1 for len=0).
// Backpressure: result held in DONE until res_ready_i; requests refused while busy. MULTADD_DOT_SEQ_OVF_EN enables sticky overflow.
module multadd_dot_seq
    import multadd_pkg::*;
#(
    parameter int  vdw_p = 32,
    parameter int  els_p = 16,
    localparam int aw    = $clog2(els_p),
    localparam int lw    = $clog2(els_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_v_i,
    output logic             start_ready_o,
    input  logic [lw-1:0]    len_i,
    input  logic [aw-1:0]    a_base_i,
    input  logic [aw-1:0]    b_base_i,
    output logic             rd_v_o,
    output logic [aw-1:0]    rd_addr_a_o,
    output logic [aw-1:0]    rd_addr_b_o,
    input  logic [vdw_p-1:0] rd_data_a_i,
    input  logic [vdw_p-1:0] rd_data_b_i,
    output logic [vdw_p-1:0] ma_a_o,
    output logic [vdw_p-1:0] ma_b_o,
    output logic [1:0]       ma_alu_op_o,
    output logic             ma_use_fma_o,
    output logic             ma_fma_first_o,
    input  logic [vdw_p-1:0] ma_data_i,
    input  logic             ma_flag_overflow_i,
    output logic             res_v_o,
    input  logic             res_ready_i,
    output logic [vdw_p-1:0] res_data_o,
    output logic             res_overflow_o
);

    localparam logic [1:0] DRAIN_LAST_C = 2'(MULTADD_LAT_C);

    seq_state_e    r_state;
    seq_state_e    w_state_nxt;
    logic          w_accept;
    logic [lw-1:0] w_len_sat;
    logic          w_first;
    logic          w_last;
    logic          r_op_v;
    logic          r_op_first;
    logic [1:0]    r_drain_cnt;
    logic [vdw_p-1:0] r_res_data;

    assign w_len_sat = lw'(sat_len(int'(len_i), els_p));
    assign w_accept  = (r_state == ST_IDLE) && start_v_i;

    multadd_dot_addr_gen #(
        .els_p (els_p)
    ) u_addr_gen (
        .i_clk     (clk_i),
        .i_reset_n (reset_n_i),
        .i_load    (w_accept),
        .i_len     (w_len_sat),
        .i_a_base  (a_base_i),
        .i_b_base  (b_base_i),
        .i_adv     (rd_v_o),
        .o_addr_a  (rd_addr_a_o),
        .o_addr_b  (rd_addr_b_o),
        .o_first   (w_first),
        .o_last    (w_last)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_v_i) w_state_nxt = (w_len_sat == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (w_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == DRAIN_LAST_C) w_state_nxt = ST_DONE;
            ST_DONE:  if (res_ready_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // DRAIN covers the last operand cycle plus the multadd latency, so use_fma spans it whole
    always_comb begin
        start_ready_o = (r_state == ST_IDLE);
        rd_v_o        = (r_state == ST_ISSUE);
        res_v_o       = (r_state == ST_DONE);
        ma_use_fma_o  = r_op_v || (r_state == ST_DRAIN);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_op_v      <= 1'b0;
            r_op_first  <= 1'b0;
            r_drain_cnt <= '0;
            r_res_data  <= '0;
        end else begin
            r_op_v      <= rd_v_o;
            r_op_first  <= rd_v_o && w_first;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            if (w_accept) begin
                r_res_data <= '0;
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt == DRAIN_LAST_C)) begin
                r_res_data <= ma_data_i;
            end
        end
    end

    assign ma_a_o         = r_op_v ? rd_data_a_i : '0;
    assign ma_b_o         = r_op_v ? rd_data_b_i : '0;
    assign ma_fma_first_o = r_op_first;
    assign ma_alu_op_o    = ALU_MUL;
    assign res_data_o     = r_res_data;

`ifdef MULTADD_DOT_SEQ_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (ma_use_fma_o && ma_flag_overflow_i) begin
            r_ovf <= 1'b1;
        end
    end

    assign res_overflow_o = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf   = ma_flag_overflow_i;
    assign res_overflow_o = 1'b0;
`endif

endmodule
